axi_lite_wr_rd_check_master: RTL and testbench

//   AXI4-Lite master traffic engine that feeds the AXI4-Lite slave register stage.
//   A rising edge on INIT_AXI_TXN starts a fixed sequence: N single-beat writes of

---
 rtl/axi_lite_pkg.sv | 21 ++
 rtl/axi_lite_wr_rd_check_master.sv | 221 ++++++++++++++++++++++
 tb/tb_axi_lite_wr_rd_check_master.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, default protection and the
// state encoding of the write-then-read check master.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ISSUE,
    ST_WR_RESP,
    ST_RD_ISSUE,
    ST_RD_DATA,
    ST_DONE
  } wr_rd_state_e;

endpackage

// File: rtl/axi_lite_wr_rd_check_master.sv
// AXI4-Lite traffic engine: on a start edge writes N incrementing words, reads
// them back, and flags any bad response or data mismatch on ERROR.
module axi_lite_wr_rd_check_master
  import axi_lite_pkg::*;
#(
  parameter int                            C_M_AXI_ADDR_WIDTH         = 32,
  parameter int                            C_M_AXI_DATA_WIDTH         = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
  parameter int                            C_M_TRANSACTIONS_NUM       = 4,
  parameter logic [C_M_AXI_DATA_WIDTH-1:0] C_DATA_SEED                = 32'h0000_0001
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            INIT_AXI_TXN,
  output logic                            TXN_DONE,
  output logic                            ERROR,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int               IDX_W    = $clog2(C_M_TRANSACTIONS_NUM + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_M_TRANSACTIONS_NUM - 1);

  // Address add is done at full bus width so the window never wraps.
  function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] word_addr(input logic [IDX_W-1:0] i);
    return C_M_TARGET_SLAVE_BASE_ADDR + (C_M_AXI_ADDR_WIDTH'(i) << 2);
  endfunction

  function automatic logic [C_M_AXI_DATA_WIDTH-1:0] word_data(input logic [IDX_W-1:0] i);
    return C_DATA_SEED + C_M_AXI_DATA_WIDTH'(i);
  endfunction

  wr_rd_state_e                  state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic                          init_p1, init_p2;
  logic                          start;
  logic                          issued_q, issued_d;
  logic                          aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                          awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                          bready_q, bready_d;
  logic                          arvalid_q, arvalid_d, rready_q, rready_d;
  logic                          txn_done_q, txn_done_d, error_q, error_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                          aw_fire, w_fire, aw_all, w_all;

  assign start   = init_p1 & ~init_p2;
  assign aw_fire = awvalid_q & M_AXI_AWREADY;
  assign w_fire  = wvalid_q & M_AXI_WREADY;
  assign aw_all  = aw_done_q | aw_fire;
  assign w_all   = w_done_q | w_fire;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    issued_d   = issued_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    txn_done_d = txn_done_q;
    error_d    = error_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    araddr_d   = araddr_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_WR_ISSUE;
          idx_d      = '0;
          issued_d   = 1'b0;
          txn_done_d = 1'b0;
          error_d    = 1'b0;
        end
      end

      ST_WR_ISSUE: begin
        if (!issued_q) begin
          issued_d  = 1'b1;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          awaddr_d  = word_addr(idx_q);
          wdata_d   = word_data(idx_q);
        end else begin
          // AW and W retire independently; move on once both have gone.
          if (aw_fire) awvalid_d = 1'b0;
          if (w_fire)  wvalid_d  = 1'b0;
          aw_done_d = aw_all;
          w_done_d  = w_all;
          if (aw_all && w_all) begin
            state_d  = ST_WR_RESP;
            bready_d = 1'b1;
          end
        end
      end

      ST_WR_RESP: begin
        if (M_AXI_BVALID && bready_q) begin
          bready_d = 1'b0;
          issued_d = 1'b0;
          if (M_AXI_BRESP != RESP_OKAY) error_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_RD_ISSUE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_WR_ISSUE;
          end
        end
      end

      ST_RD_ISSUE: begin
        if (!issued_q) begin
          issued_d  = 1'b1;
          arvalid_d = 1'b1;
          araddr_d  = word_addr(idx_q);
        end else if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        if (M_AXI_RVALID && rready_q) begin
          rready_d = 1'b0;
          issued_d = 1'b0;
          if (M_AXI_RRESP != RESP_OKAY || M_AXI_RDATA != word_data(idx_q)) error_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d    = ST_DONE;
            txn_done_d = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_RD_ISSUE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      init_p1    <= 1'b0;
      init_p2    <= 1'b0;
      issued_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      txn_done_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      init_p1    <= INIT_AXI_TXN;
      init_p2    <= init_p1;
      issued_q   <= issued_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      txn_done_q <= txn_done_d;
      error_q    <= error_d;
    end
  end

  // Address/data payload only matters while its VALID is high.
  always_ff @(posedge ACLK) begin
    awaddr_q <= awaddr_d;
    wdata_q  <= wdata_d;
    araddr_q <= araddr_d;
  end

  assign TXN_DONE      = txn_done_q;
  assign ERROR         = error_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = PROT_DEFAULT;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = PROT_DEFAULT;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_wr_rd_check_master.sv
// Bench for axi_lite_wr_rd_check_master: a register-file slave with tunable
// ready/response delays and fault injection, checked against a scoreboard.
`timescale 1ns/1ps
module tb_axi_lite_wr_rd_check_master;
  import axi_lite_pkg::*;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam logic [31:0] SEED  = 32'h0000_0001;
  localparam int          N     = 4;
  localparam int          LIMIT = 3000;

  logic        tb_ACLK = 1'b0;
  logic        tb_ARESET = 1'b1;
  logic        tb_INIT_AXI_TXN = 1'b0;
  logic        tb_TXN_DONE, tb_ERROR;
  logic [31:0] tb_AWADDR;
  logic [2:0]  tb_AWPROT;
  logic        tb_AWVALID;
  logic        tb_AWREADY = 1'b0;
  logic [31:0] tb_WDATA;
  logic [3:0]  tb_WSTRB;
  logic        tb_WVALID;
  logic        tb_WREADY = 1'b0;
  logic [1:0]  tb_BRESP = 2'b00;
  logic        tb_BVALID = 1'b0;
  logic        tb_BREADY;
  logic [31:0] tb_ARADDR;
  logic [2:0]  tb_ARPROT;
  logic        tb_ARVALID;
  logic        tb_ARREADY = 1'b0;
  logic [31:0] tb_RDATA = 32'h0;
  logic [1:0]  tb_RRESP = 2'b00;
  logic        tb_RVALID = 1'b0;
  logic        tb_RREADY;

  always #5 tb_ACLK = ~tb_ACLK;

  axi_lite_wr_rd_check_master dut (
    .ACLK(tb_ACLK), .ARESET(tb_ARESET), .INIT_AXI_TXN(tb_INIT_AXI_TXN),
    .TXN_DONE(tb_TXN_DONE), .ERROR(tb_ERROR),
    .M_AXI_AWADDR(tb_AWADDR), .M_AXI_AWPROT(tb_AWPROT), .M_AXI_AWVALID(tb_AWVALID),
    .M_AXI_AWREADY(tb_AWREADY),
    .M_AXI_WDATA(tb_WDATA), .M_AXI_WSTRB(tb_WSTRB), .M_AXI_WVALID(tb_WVALID),
    .M_AXI_WREADY(tb_WREADY),
    .M_AXI_BRESP(tb_BRESP), .M_AXI_BVALID(tb_BVALID), .M_AXI_BREADY(tb_BREADY),
    .M_AXI_ARADDR(tb_ARADDR), .M_AXI_ARPROT(tb_ARPROT), .M_AXI_ARVALID(tb_ARVALID),
    .M_AXI_ARREADY(tb_ARREADY),
    .M_AXI_RDATA(tb_RDATA), .M_AXI_RRESP(tb_RRESP), .M_AXI_RVALID(tb_RVALID),
    .M_AXI_RREADY(tb_RREADY)
  );

  typedef struct {
    int   aw_dly;
    int   w_dly;
    int   b_dly;
    int   bad_b;
    int   bad_r;
    bit   repulse;
    logic exp_err;
    int   exp_cyc;
  } row_t;

  row_t rows [6];

  int n_total = 0;
  int n_pass  = 0;

  // Slave configuration and observation counters.
  int aw_dly = 0, w_dly = 0, b_dly = 0, bad_b = -1, bad_r = -1;
  int aw_beats = 0, w_beats = 0, b_beats = 0, ar_beats = 0, r_beats = 0, hold_viol = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  bit got_aw = 0, got_w = 0, b_wait = 0, b_arm = 0, r_wait = 0, r_arm = 0;
  bit aw_pend = 0, w_pend = 0, ar_pend = 0;
  logic [31:0] aw_addr_l = 32'h0, w_data_l = 32'h0;
  logic [31:0] mem [0:3];
  logic [1:0]  rd_word = 2'd0;

  logic [31:0] exp_aw_q [$];
  logic [31:0] exp_w_q  [$];
  logic [31:0] exp_ar_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
  endtask

  // One slave decision per falling edge; a READY/VALID raised here is
  // sampled by the DUT on the next rising edge.
  task automatic slave_step();
    logic [31:0] off;
    if (tb_ARESET) begin
      tb_AWREADY = 0; tb_WREADY = 0; tb_BVALID = 0; tb_ARREADY = 0; tb_RVALID = 0;
      got_aw = 0; got_w = 0; b_wait = 0; b_arm = 0; r_wait = 0; r_arm = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; aw_pend = 0; w_pend = 0; ar_pend = 0;
      return;
    end
    if (b_arm) tb_BVALID = 0;
    if (r_arm) tb_RVALID = 0;
    if (got_aw && got_w) begin
      off = aw_addr_l - BASE;
      mem[off[3:2]] = w_data_l;
      got_aw = 0; got_w = 0; b_wait = 1; b_cnt = 0;
    end
    if (aw_pend && !tb_AWVALID) hold_viol++;
    if (w_pend && !tb_WVALID) hold_viol++;
    if (ar_pend && !tb_ARVALID) hold_viol++;

    if (tb_AWREADY) begin
      tb_AWREADY = 0; aw_cnt = 0;
    end else if (tb_AWVALID) begin
      if (aw_cnt >= aw_dly) begin
        tb_AWREADY = 1; aw_beats++; got_aw = 1; aw_addr_l = tb_AWADDR;
        chk("aw_prot", 32'(tb_AWPROT), 32'(PROT_DEFAULT));
        if (exp_aw_q.size() != 0) chk("aw_addr", tb_AWADDR, exp_aw_q.pop_front());
      end else aw_cnt++;
    end
    aw_pend = tb_AWVALID && !tb_AWREADY;

    if (tb_WREADY) begin
      tb_WREADY = 0; w_cnt = 0;
    end else if (tb_WVALID) begin
      if (w_cnt >= w_dly) begin
        tb_WREADY = 1; w_beats++; got_w = 1; w_data_l = tb_WDATA;
        chk("w_strb", 32'(tb_WSTRB), 32'h0000_000F);
        if (exp_w_q.size() != 0) chk("w_data", tb_WDATA, exp_w_q.pop_front());
      end else w_cnt++;
    end
    w_pend = tb_WVALID && !tb_WREADY;

    if (b_wait) begin
      if (b_cnt >= b_dly) begin
        tb_BVALID = 1;
        tb_BRESP  = (b_beats == bad_b) ? RESP_SLVERR : RESP_OKAY;
        b_beats++; b_wait = 0;
      end else b_cnt++;
    end
    b_arm = tb_BVALID && tb_BREADY;

    if (tb_ARREADY) begin
      tb_ARREADY = 0; r_wait = 1;
    end else if (tb_ARVALID) begin
      tb_ARREADY = 1; ar_beats++;
      off = tb_ARADDR - BASE;
      rd_word = off[3:2];
      if (exp_ar_q.size() != 0) chk("ar_addr", tb_ARADDR, exp_ar_q.pop_front());
    end
    ar_pend = tb_ARVALID && !tb_ARREADY;

    if (r_wait) begin
      tb_RVALID = 1; tb_RRESP = RESP_OKAY;
      if (r_beats == bad_r) begin
        tb_RDATA = 32'hDEAD_BEEF;
        chk("error_before_bad_read", 32'(tb_ERROR), 32'h0);
      end else tb_RDATA = mem[rd_word];
      r_beats++; r_wait = 0;
    end
    r_arm = tb_RVALID && tb_RREADY;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    forever begin
      @(negedge tb_ACLK);
      slave_step();
    end
  end

  task automatic start_run(input row_t r);
    aw_dly = r.aw_dly; w_dly = r.w_dly; b_dly = r.b_dly; bad_b = r.bad_b; bad_r = r.bad_r;
    aw_beats = 0; w_beats = 0; b_beats = 0; ar_beats = 0; r_beats = 0; hold_viol = 0;
    exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
    for (int i = 0; i < N; i++) begin
      exp_aw_q.push_back(BASE + 32'(4 * i));
      exp_w_q.push_back(SEED + 32'(i));
      exp_ar_q.push_back(BASE + 32'(4 * i));
    end
    @(negedge tb_ACLK);
    tb_INIT_AXI_TXN = 1;
  endtask

  task automatic finish_run(input row_t r);
    int cyc = 0;
    bit done_seen = 0;
    while (cyc < LIMIT && !done_seen) begin
      @(posedge tb_ACLK);
      @(negedge tb_ACLK);
      cyc++;
      if (cyc == 2) tb_INIT_AXI_TXN = 0;
      if (r.repulse && cyc == 10) tb_INIT_AXI_TXN = 1;
      if (r.repulse && cyc == 12) tb_INIT_AXI_TXN = 0;
      if (cyc == 3) chk("start_clears_done_err", 32'({tb_TXN_DONE, tb_ERROR}), 32'h0);
      if (cyc > 3 && tb_TXN_DONE) done_seen = 1;
    end
    chk("txn_done_reached", 32'(done_seen), 32'h1);
    if (r.exp_cyc != 0) chk("done_latency", 32'(cyc), 32'(r.exp_cyc));
    chk("error_flag", 32'(tb_ERROR), 32'(r.exp_err));
    chk("aw_beats", 32'(aw_beats), 32'(N));
    chk("w_beats", 32'(w_beats), 32'(N));
    chk("b_beats", 32'(b_beats), 32'(N));
    chk("ar_beats", 32'(ar_beats), 32'(N));
    chk("r_beats", 32'(r_beats), 32'(N));
    chk("valid_held", 32'(hold_viol), 32'h0);
    repeat (3) @(negedge tb_ACLK);
    chk("done_held", 32'({tb_TXN_DONE, tb_ERROR}), 32'({1'b1, r.exp_err}));
    chk("scoreboard_empty", 32'(exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size()), 32'h0);
  endtask

  initial begin
    row_t    rr;
    bit      found;
    rows[0] = '{aw_dly: 0, w_dly: 0, b_dly: 0, bad_b: -1, bad_r: -1, repulse: 0, exp_err: 1'b0, exp_cyc: 26};
    rows[1] = '{aw_dly: 3, w_dly: 0, b_dly: 5, bad_b: -1, bad_r: -1, repulse: 0, exp_err: 1'b0, exp_cyc: 0};
    rows[2] = '{aw_dly: 0, w_dly: 0, b_dly: 0, bad_b:  1, bad_r: -1, repulse: 0, exp_err: 1'b1, exp_cyc: 26};
    rows[3] = '{aw_dly: 0, w_dly: 0, b_dly: 0, bad_b: -1, bad_r:  3, repulse: 0, exp_err: 1'b1, exp_cyc: 26};
    rows[4] = '{aw_dly: 0, w_dly: 0, b_dly: 0, bad_b: -1, bad_r: -1, repulse: 1, exp_err: 1'b0, exp_cyc: 26};
    rows[5] = '{aw_dly: 0, w_dly: 2, b_dly: 1, bad_b: -1, bad_r: -1, repulse: 0, exp_err: 1'b0, exp_cyc: 0};

    tb_ARESET = 1;
    repeat (3) @(negedge tb_ACLK);
    chk("reset_outputs", 32'({tb_AWVALID, tb_WVALID, tb_BREADY, tb_ARVALID, tb_RREADY,
                             tb_TXN_DONE, tb_ERROR}), 32'h0);
    tb_ARESET = 0;
    repeat (2) @(negedge tb_ACLK);

    for (int i = 0; i < 6; i++) begin
      start_run(rows[i]);
      finish_run(rows[i]);
    end

    // Reset while the second write waits for its response.
    rr = '{aw_dly: 0, w_dly: 0, b_dly: 3, bad_b: -1, bad_r: -1, repulse: 0, exp_err: 1'b0, exp_cyc: 0};
    start_run(rr);
    found = 0;
    for (int c = 1; c <= 200 && !found; c++) begin
      @(negedge tb_ACLK);
      if (c == 2) tb_INIT_AXI_TXN = 0;
      if (aw_beats == 2 && tb_BREADY) found = 1;
    end
    tb_INIT_AXI_TXN = 0;
    chk("reached_second_wr_resp", 32'(found), 32'h1);
    tb_ARESET = 1;
    @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    chk("midrun_reset_outputs", 32'({tb_AWVALID, tb_WVALID, tb_BREADY, tb_ARVALID, tb_RREADY,
                                    tb_TXN_DONE, tb_ERROR}), 32'h0);
    @(negedge tb_ACLK);
    tb_ARESET = 0;
    repeat (6) @(negedge tb_ACLK);
    chk("no_beats_after_reset", 32'({8'(aw_beats), 8'(w_beats), 8'(ar_beats)}), 32'h0002_0200);
    chk("idle_after_reset", 32'({tb_AWVALID, tb_WVALID, tb_ARVALID, tb_TXN_DONE}), 32'h0);
    start_run(rows[0]);
    finish_run(rows[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

endmodule
